// File: rtl/riscv_v_inst_queue.sv
// Vector instruction queue: small FIFO between vector dispatch and vector decode.
// The head entry is read combinationally. A NOP is shown whenever the queue is empty.
module riscv_v_inst_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_pipe,
    input  logic             inst_valid_if,
    input  logic [31:0]      inst_if,
    output logic             inst_ready_if,
    input  logic             stall_id,
    output logic [31:0]      instruction_id,
    output logic             inst_valid_id,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow_err
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             push;
    logic             pop;

    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign inst_ready_if = ~full & ~clear_pipe;
    assign inst_valid_id = ~empty;
    assign instruction_id = empty ? NOP : mem[rd_ptr];
    assign overflow_err  = overflow_q;

    assign push = inst_valid_if & inst_ready_if;
    assign pop  = inst_valid_id & ~stall_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_pipe) begin
            // Flush only invalidates entries; the array keeps its stale data.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (inst_valid_if & full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= inst_if;
        end
    end

endmodule

// File: doc/riscv_v_inst_queue.md
# riscv_v_inst_queue

Vector instruction queue between the integer pipeline's vector dispatch point and the vector decode stage. It buffers vector instructions in a small FIFO so the integer core is not held up by short vector decode stalls. It presents the oldest instruction to decode as `instruction_id` with a valid flag, and pops it when decode is not stalled. It empties synchronously on `clear_pipe`, using the same flush semantics as the rest of the vector pipeline.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, do not override)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- clear_pipe  in  1  synchronous pipeline flush
- inst_valid_if  in  1  upstream presents a vector instruction
- inst_if  in  riscv_instruction_t  instruction from upstream
- inst_ready_if  out  1  queue accepts push this cycle
- stall_id  in  1  vector decode cannot consume this cycle
- instruction_id  out  riscv_instruction_t  head instruction to decode
- inst_valid_id  out  1  instruction_id holds a real instruction
- count  out  CNT_W  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow_err  out  1  sticky flag: push attempted while not ready

## Operation
- Storage: DEPTH-entry register array, plus a write pointer and a read pointer, each log2(DEPTH) bits and wrapping modulo DEPTH, plus `count`.
- Push condition: `push = inst_valid_if & inst_ready_if`. The instruction is written at the write pointer, and the write pointer increments.
- Pop condition: `pop = inst_valid_id & ~stall_id`. The read pointer increments.
- `inst_ready_if = ~full & ~clear_pipe`.
- `inst_valid_id = ~empty`.
- `instruction_id`:
  - When not empty, it is the entry at the read pointer.
  - When empty, it is the NOP encoding 32'h0000_0013, so decode sees a benign instruction.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- No bypass: an instruction pushed into an empty queue becomes visible on `instruction_id` in the following cycle.
- Full: `inst_ready_if` is 0. A pop in that cycle frees an entry, but the ready seen upstream is still 0; no same-cycle refill.
- clear_pipe has highest priority:
  - Next cycle: count=0, both pointers=0, `inst_valid_id`=0.
  - Any concurrent push or pop in that cycle is discarded.
  - Stored entries are not zeroed; they are only invalidated.
- overflow_err: set when `inst_valid_if & ~inst_ready_if & ~clear_pipe & full`. It is cleared only by `rst`. The offending instruction is dropped and state is unchanged.
- `stall_id` has no effect while empty.

## Timing
- Reset values (asynchronous, while rst=1):
  - pointers=0, count=0
  - empty=1, full=0
  - inst_valid_id=0, instruction_id=32'h0000_0013
  - inst_ready_if=1 (if clear_pipe=0)
  - overflow_err=0
  - storage contents don't-care
- Reset asserted mid-operation clears all queued instructions immediately, without waiting for a clock edge.
- Latency from push to availability at decode: 1 cycle.
- Steady-state throughput: 1 instruction/cycle with simultaneous push and pop at any occupancy from 1 to DEPTH−1.
- count, empty and full are registered-state derived. inst_ready_if depends combinationally only on full and clear_pipe; there is no combinational path from stall_id to inst_ready_if.
- instruction_id is a combinational read of the array at the read pointer.
- Ordering: strict FIFO, including across pointer wrap-around.

## Test plan
- Reset then idle: assert rst for 2 cycles, release → empty=1, count=0, inst_valid_id=0, instruction_id=32'h13, inst_ready_if=1, overflow_err=0.
- Fill and drain: hold stall_id=1 and push A0..A3 (DEPTH=4) → count=4, full=1, inst_ready_if=0. Then drop stall_id → A0, A1, A2, A3 pop on consecutive cycles, then empty=1.
- Streaming wrap: push and pop simultaneously every cycle for 10 instructions, starting from count=1 → count stays 1, output order matches input order, pointers wrap twice without loss.
- Flush: with count=3 and a push asserted, assert clear_pipe for 1 cycle → next cycle count=0, inst_valid_id=0, the pushed instruction is absent, inst_ready_if=0 during the flush cycle.
- Overflow: at full with stall_id=1, drive inst_valid_if=1 → overflow_err=1 next cycle and stays set, count stays 4, contents unchanged. Only a subsequent rst clears it.
- Async reset mid-stream: with count=2, assert rst between clock edges → empty=1 and inst_valid_id=0 immediately. After release, the first push appears on instruction_id one cycle later.
